// File: rtl/bada_pkg.sv
// Shared constants and types for the BADA array output path.
package bada_pkg;

    localparam int unsigned LANE_W     = 64;
    localparam int unsigned N_LANES    = 20;
    localparam int unsigned BEAT_LANES = 4;
    localparam int unsigned BEATS      = N_LANES / BEAT_LANES;
    localparam int unsigned CNT_W      = 16;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } drain_state_t;

    typedef logic [LANE_W-1:0]         lane_t;
    typedef logic [N_LANES*LANE_W-1:0] frame_t;

    // Index width for a beat counter; never zero so a single-beat frame still has a port.
    function automatic int unsigned beat_idx_w(input int unsigned beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/bada_frame_buf.sv
// Two-entry frame register file with a full-frame write port and a beat-slice read port.
module bada_frame_buf #(
    parameter int unsigned LANE_W     = bada_pkg::LANE_W,
    parameter int unsigned N_LANES    = bada_pkg::N_LANES,
    parameter int unsigned BEAT_LANES = bada_pkg::BEAT_LANES,
    parameter int unsigned BEAT_W     = 3
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         wr_en,
    input  logic                         wr_ptr,
    input  logic [N_LANES*LANE_W-1:0]    frame,
    input  logic                         rd_ptr,
    input  logic [BEAT_W-1:0]            beat,
    output logic [BEAT_LANES*LANE_W-1:0] beat_data
);
    import bada_pkg::*;

    localparam int unsigned FRAME_BITS = N_LANES * LANE_W;
    localparam int unsigned BEAT_BITS  = BEAT_LANES * LANE_W;
    localparam int unsigned NBEATS     = N_LANES / BEAT_LANES;

    logic [FRAME_BITS-1:0] mem_q [2];
    logic [FRAME_BITS-1:0] rd_frame;

    // Entry storage; cleared on reset so the read port shows zeros until first write.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else if (wr_en) begin
            mem_q[wr_ptr] <= frame;
        end
    end

    assign rd_frame = rd_ptr ? mem_q[1] : mem_q[0];

    // Beat slice select; lane 0 sits in the LSBs and goes out first.
    always_comb begin
        beat_data = '0;
        for (int b = 0; b < NBEATS; b++) begin
            if (beat == BEAT_W'(b)) begin
                beat_data = rd_frame[b*BEAT_BITS +: BEAT_BITS];
            end
        end
    end

endmodule

// File: rtl/bada_odata_drain.sv
// Captures BADA_array odata frames into a ping-pong buffer and streams them as narrow beats.
module bada_odata_drain #(
    parameter int unsigned LANE_W     = bada_pkg::LANE_W,
    parameter int unsigned N_LANES    = bada_pkg::N_LANES,
    parameter int unsigned BEAT_LANES = bada_pkg::BEAT_LANES,
    parameter int unsigned CNT_W      = bada_pkg::CNT_W,
    localparam int unsigned BEAT_W    = bada_pkg::beat_idx_w(N_LANES / BEAT_LANES)
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         in_valid,
    input  logic [N_LANES*LANE_W-1:0]    in_data,
    output logic                         in_ready,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [BEAT_LANES*LANE_W-1:0] m_data,
    output logic                         m_last,
    output logic [BEAT_W-1:0]            m_beat,
    output logic                         ovf,
    input  logic                         ovf_clr,
    output logic [CNT_W-1:0]             frame_cnt
);
    import bada_pkg::*;

    localparam int unsigned NBEATS = N_LANES / BEAT_LANES;

    localparam logic [0:0] ST_IDLE   = IDLE;
    localparam logic [0:0] ST_STREAM = STREAM;

    if (N_LANES % BEAT_LANES != 0) begin : g_bad_lanes
        $error("bada_odata_drain: N_LANES must be a multiple of BEAT_LANES");
    end

    logic [1:0]        count_q, count_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [0:0]        state_q, state_d;
    logic              ovf_q, ovf_d;
    logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;

    logic accept;
    logic drop;
    logic handshake;
    logic last_beat;
    logic frame_done;

    // Handshake decode; in_ready depends only on the registered occupancy.
    always_comb begin
        in_ready   = (count_q < 2'd2);
        accept     = in_valid & in_ready;
        drop       = in_valid & ~in_ready;
        m_valid    = (state_q == ST_STREAM);
        last_beat  = (beat_q == BEAT_W'(NBEATS - 1));
        handshake  = m_valid & m_ready;
        frame_done = handshake & last_beat;
        m_last     = m_valid & last_beat;
        m_beat     = beat_q;
        ovf        = ovf_q;
        frame_cnt  = frame_cnt_q;
    end

    // Occupancy, pointer and beat bookkeeping.
    always_comb begin
        count_d     = count_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        beat_d      = beat_q;
        frame_cnt_d = frame_cnt_q;

        // Accept and release in the same cycle leave the occupancy unchanged.
        if (accept && !frame_done) begin
            count_d = count_q + 2'd1;
        end else if (!accept && frame_done) begin
            count_d = count_q - 2'd1;
        end

        if (accept) begin
            wr_ptr_d = ~wr_ptr_q;
        end

        if (handshake) begin
            if (last_beat) begin
                beat_d      = '0;
                rd_ptr_d    = ~rd_ptr_q;
                frame_cnt_d = frame_cnt_q + CNT_W'(1);
            end else begin
                beat_d = beat_q + BEAT_W'(1);
            end
        end
    end

    // Sticky overflow flag; a new drop beats a coincident clear.
    always_comb begin
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    // Drain FSM; looks at next occupancy so a fresh frame streams the cycle after capture.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (count_d != 2'd0) begin
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (count_d == 2'd0) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q     <= 2'd0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            beat_q      <= '0;
            state_q     <= ST_IDLE;
            ovf_q       <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            beat_q      <= beat_d;
            state_q     <= state_d;
            ovf_q       <= ovf_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    bada_frame_buf #(
        .LANE_W     (LANE_W),
        .N_LANES    (N_LANES),
        .BEAT_LANES (BEAT_LANES),
        .BEAT_W     (BEAT_W)
    ) u_frame_buf (
        .clk       (clk),
        .rstn      (rstn),
        .wr_en     (accept),
        .wr_ptr    (wr_ptr_q),
        .frame     (in_data),
        .rd_ptr    (rd_ptr_q),
        .beat      (beat_q),
        .beat_data (m_data)
    );

`ifndef SYNTHESIS
    // Occupancy can never exceed the two entries.
    always @(posedge clk) begin
        if (rstn) begin
            assert (count_q != 2'd3) else $error("drain occupancy out of range");
        end
    end
`endif

endmodule

// File: tb/tb_bada_odata_drain.sv
// Scoreboard bench for bada_odata_drain: directed scenarios plus a randomized phase.
module tb_bada_odata_drain;

    localparam int LW    = 64;
    localparam int NL    = 20;
    localparam int BL    = 4;
    localparam int CW    = 4;
    localparam int BEATS = NL / BL;
    localparam int FW    = NL * LW;
    localparam int BW    = BL * LW;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          in_valid = 1'b0;
    logic [FW-1:0] in_data = '0;
    logic          in_ready;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [BW-1:0] m_data;
    logic          m_last;
    logic [2:0]    m_beat;
    logic          ovf;
    logic          ovf_clr = 1'b0;
    logic [CW-1:0] frame_cnt;

    bada_odata_drain #(
        .LANE_W     (LW),
        .N_LANES    (NL),
        .BEAT_LANES (BL),
        .CNT_W      (CW)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .m_beat    (m_beat),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [BW-1:0] data;
        bit            last;
        int            idx;
    } beat_t;

    // Reference model: frames are queued as their expected beats; occ counts whole frames held.
    beat_t exp_q[$];
    int    occ = 0;
    bit    exp_ovf = 0;
    int    exp_cnt = 0;
    int    checks = 0;
    int    errors = 0;
    int    last_seen = 0;

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: compares DUT outputs to the model, then advances the model across the next edge.
    always @(negedge clk) begin
        if (!rstn) begin
            exp_q.delete();
            occ     = 0;
            exp_ovf = 0;
            exp_cnt = 0;
        end else begin
            int occ0;
            chk("m_valid", m_valid, (occ > 0));
            chk("in_ready", in_ready, (occ < 2));
            chk("ovf", ovf, exp_ovf);
            chk("frame_cnt", frame_cnt, BW'(exp_cnt % (1 << CW)));
            if (occ > 0 && exp_q.size() > 0) begin
                chk("m_data", m_data, exp_q[0].data);
                chk("m_last", m_last, exp_q[0].last);
                chk("m_beat", m_beat, BW'(exp_q[0].idx));
            end
            if (m_valid && m_ready && m_last) last_seen++;

            occ0 = occ;
            if (in_valid) begin
                if (occ0 < 2) begin
                    for (int k = 0; k < BEATS; k++) begin
                        beat_t b;
                        logic [FW-1:0] f;
                        f      = in_data;
                        b.data = f[k*BW +: BW];
                        b.last = (k == BEATS - 1);
                        b.idx  = k;
                        exp_q.push_back(b);
                    end
                    occ++;
                end else begin
                    exp_ovf = 1;
                end
            end
            if (!(in_valid && occ0 == 2) && ovf_clr) exp_ovf = 0;
            if (occ0 > 0 && m_ready && exp_q.size() > 0) begin
                beat_t b;
                b = exp_q.pop_front();
                if (b.last) begin
                    occ--;
                    exp_cnt++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [FW-1:0] f);
        in_data  = f;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    function automatic logic [FW-1:0] rnd_frame();
        logic [FW-1:0] f;
        for (int i = 0; i < FW / 32; i++) f[i*32 +: 32] = $urandom;
        return f;
    endfunction

    function automatic logic [FW-1:0] ramp_frame();
        logic [FW-1:0] f;
        for (int i = 0; i < NL; i++) f[i*LW +: LW] = {4{16'(i)}};
        return f;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_m_valid"}, m_valid, 0);
        chk({tag, "_m_last"}, m_last, 0);
        chk({tag, "_m_beat"}, m_beat, 0);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_ovf"}, ovf, 0);
        chk({tag, "_frame_cnt"}, frame_cnt, 0);
        chk({tag, "_m_data"}, m_data, 0);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #1;
        check_reset_outputs("rst");
        tick();
        tick();
        rstn = 1'b1;
        tick();
    endtask

    initial begin
        int l0;
        #1;
        check_reset_outputs("por");
        tick();
        tick();
        rstn = 1'b1;
        tick();

        // 1: single ramp frame, sink always ready.
        m_ready = 1'b1;
        send(ramp_frame());
        repeat (8) tick();
        chk("t1_frame_cnt", frame_cnt, 1);

        // 2: back-to-back frames.
        send(rnd_frame());
        send(rnd_frame());
        repeat (14) tick();
        chk("t2_frame_cnt", frame_cnt, 3);

        // 3: overflow with sink stalled, then drain and clear.
        m_ready = 1'b0;
        send(rnd_frame());
        send(rnd_frame());
        send(rnd_frame());
        tick();
        chk("t3_ovf", ovf, 1);
        chk("t3_in_ready", in_ready, 0);
        m_ready = 1'b1;
        repeat (14) tick();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        tick();
        chk("t3_ovf_clr", ovf, 0);
        chk("t3_frame_cnt", frame_cnt, 5);

        // 4: backpressure 1010 during a frame.
        m_ready = 1'b0;
        l0 = last_seen;
        send(rnd_frame());
        for (int i = 0; i < 12; i++) begin
            m_ready = (i % 2 == 0);
            tick();
        end
        m_ready = 1'b1;
        repeat (4) tick();
        chk("t4_last_count", BW'(last_seen - l0), 1);
        chk("t4_frame_cnt", frame_cnt, 6);

        // 5: reset mid-frame after two beats, then a fresh frame.
        send(rnd_frame());
        tick();
        tick();
        do_reset();
        send(ramp_frame());
        repeat (8) tick();
        chk("t5_frame_cnt", frame_cnt, 1);

        // 6: periodic frames every 10 cycles; counter wraps at 16.
        do_reset();
        for (int n = 0; n < 17; n++) begin
            send(rnd_frame());
            repeat (9) tick();
        end
        chk("t6_frame_cnt", frame_cnt, 1);
        chk("t6_ovf", ovf, 0);

        // Random traffic, random backpressure and clears.
        for (int c = 0; c < 400; c++) begin
            in_data  = rnd_frame();
            in_valid = ($urandom_range(0, 3) == 0);
            m_ready  = ($urandom_range(0, 2) != 0);
            ovf_clr  = ($urandom_range(0, 9) == 0);
            tick();
        end
        in_valid = 1'b0;
        ovf_clr  = 1'b0;
        m_ready  = 1'b1;
        repeat (16) tick();
        chk("final_idle", m_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
